// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the immediate generator:
//     imm_fmt_e    - immediate format code carried on out_fmt
//     buf_state_e  - occupancy of the two-entry output buffer
//     OPC_*        - RV32/RV64 major opcodes that carry an immediate
//     decode_fmt() - maps inst[6:0] to an immediate format
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Every listed opcode ends in 2'b11, so compressed encodings
    // (inst[1:0] != 2'b11) fall through to FMT_NONE automatically.
    function automatic imm_fmt_e decode_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            default:                        fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/riscv_skid_buf.sv
// riscv_skid_buf
//   Two-entry valid/ready buffer (output register + skid register) with
//   fully registered in_ready and out_valid.
//   Ports:
//     clk, rst_n          - clock, async active-low reset
//     flush               - synchronous discard of both entries
//     in_valid/in_ready   - upstream handshake, in_data payload
//     out_valid/out_ready - downstream handshake, out_data payload
module riscv_skid_buf
    import riscv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state;
    buf_state_e   next_state;
    logic         accept;
    logic         deliver;
    logic         load_out;
    logic         load_skid;
    logic         out_from_skid;
    logic [W-1:0] skid_data;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    // State register; in_ready and out_valid are registered copies of the
    // next state so neither depends combinationally on the other side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BUF_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != BUF_FULL);
            out_valid <= (next_state != BUF_EMPTY);
        end
    end

    // Next-state logic; flush wins over any handshake in the same cycle.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (accept) next_state = BUF_ONE;
                BUF_ONE: begin
                    if (accept && !deliver)      next_state = BUF_FULL;
                    else if (deliver && !accept) next_state = BUF_EMPTY;
                end
                BUF_FULL:  if (deliver) next_state = BUF_ONE;
                default:   next_state = BUF_EMPTY;
            endcase
        end
    end

    // Datapath controls. A new entry goes straight to the output register
    // whenever that register is (or is becoming) free; otherwise it parks
    // in the skid register. Draining FULL promotes the skid entry.
    always_comb begin
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (!flush) begin
            case (state)
                BUF_EMPTY: load_out = accept;
                BUF_ONE: begin
                    load_out  = accept && deliver;
                    load_skid = accept && !deliver;
                end
                BUF_FULL: begin
                    load_out      = deliver;
                    out_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            if (load_out)  out_data  <= out_from_skid ? skid_data : in_data;
            if (load_skid) skid_data <= in_data;
        end
    end

endmodule

// File: rtl/riscv_imm_gen.sv
// riscv_imm_gen
//   Decodes the immediate of a RISC-V instruction word, sign-extends it to
//   XLEN and returns it through a two-entry registered buffer together with
//   its format code and sideband tag.
//   Ports:
//     clk, rst_n          - clock, async active-low reset
//     flush               - discard all held entries
//     in_valid/in_ready   - input handshake for inst and in_tag
//     out_valid/out_ready - output handshake for out_imm, out_fmt, out_tag
module riscv_imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("riscv_imm_gen: XLEN must be 32 or 64");
    end

    localparam int PW = XLEN + 3 + TAG_W;

    imm_fmt_e               fmt;
    logic signed [31:0]     imm32;
    logic [XLEN-1:0]        imm;
    logic [PW-1:0]          in_data;
    logic [PW-1:0]          out_data;

    // Every format places the sign bit at inst[31], so a 32-bit signed
    // immediate is built first and then widened with one signed cast.
    always_comb begin
        fmt   = decode_fmt(inst[6:0]);
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            FMT_U: imm32 = {inst[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm     = XLEN'(imm32);
    assign in_data = {imm, fmt, in_tag};

    riscv_skid_buf #(
        .W (PW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign out_imm = out_data[PW-1 -: XLEN];
    assign out_fmt = out_data[TAG_W +: 3];
    assign out_tag = out_data[TAG_W-1:0];

endmodule

// File: tb/tb_riscv_imm_gen.sv
// tb_riscv_imm_gen
//   Drives an XLEN=32 and an XLEN=64 instance with the same stimulus and
//   compares both against hand-computed immediates, then exercises the
//   back-pressure, flush and mid-stream reset corner cases.
module tb_riscv_imm_gen;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = '0;
    logic [7:0]  in_tag = '0;

    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt32, out_fmt64;
    logic [7:0]  out_tag32, out_tag64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_imm_gen #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready32), .inst(inst), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_tag(out_tag32)
    );

    riscv_imm_gen #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready64), .inst(inst), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_tag(out_tag64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm32;
        logic [63:0] imm64;
        imm_fmt_e    fmt;
    } vec_t;

    vec_t vecs[13];

    task automatic check_value(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one instruction for exactly one accepting edge.
    task automatic apply_stimulus(input logic [31:0] i_inst, input logic [7:0] i_tag);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        inst     = i_inst;
        in_tag   = i_tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, FMT_I};
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_S};
        vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_B};
        vecs[3]  = '{32'h0080006F, 32'h00000008, 64'h0000000000000008, FMT_J};
        vecs[4]  = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, FMT_U};
        vecs[5]  = '{32'h00000033, 32'h00000000, 64'h0000000000000000, FMT_NONE};
        vecs[6]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, FMT_U};
        vecs[7]  = '{32'h00008067, 32'h00000000, 64'h0000000000000000, FMT_I};
        vecs[8]  = '{32'h00412083, 32'h00000004, 64'h0000000000000004, FMT_I};
        vecs[9]  = '{32'hFFFFF117, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, FMT_U};
        vecs[10] = '{32'hFFF00090, 32'h00000000, 64'h0000000000000000, FMT_NONE};
        vecs[11] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, FMT_J};
        vecs[12] = '{32'h00208463, 32'h00000008, 64'h0000000000000008, FMT_B};

        // Reset state, checked while rst_n is still low.
        repeat (2) @(negedge clk);
        check_value("reset out_valid32", 64'(out_valid32), 64'd0);
        check_value("reset in_ready32",  64'(in_ready32),  64'd0);
        check_value("reset out_imm32",   64'(out_imm32),   64'd0);
        check_value("reset out_fmt32",   64'(out_fmt32),   64'(FMT_NONE));
        check_value("reset out_tag32",   64'(out_tag32),   64'd0);
        check_value("reset out_imm64",   out_imm64,        64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_value("in_ready after reset release", 64'(in_ready32), 64'd1);

        // Decode table, one instruction at a time with no back-pressure.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].inst, 8'(i + 16));
            @(negedge clk);
            check_value($sformatf("vec%0d out_valid", i), 64'(out_valid32), 64'd1);
            check_value($sformatf("vec%0d imm32", i), 64'(out_imm32), 64'(vecs[i].imm32));
            check_value($sformatf("vec%0d imm64", i), out_imm64, vecs[i].imm64);
            check_value($sformatf("vec%0d fmt32", i), 64'(out_fmt32), 64'(vecs[i].fmt));
            check_value($sformatf("vec%0d fmt64", i), 64'(out_fmt64), 64'(vecs[i].fmt));
            check_value($sformatf("vec%0d tag", i), 64'(out_tag32), 64'(i + 16));
        end
        @(posedge clk);
        #1;

        // Back-to-back stream of tags 1..6 with out_ready low for 3 cycles.
        begin
            int accepted = 0;
            int delivered = 0;
            int accepts_at_stall = -1;
            int last_cycle = -1;
            logic [7:0] next_in = 8'd1;
            in_valid  = 1'b1;
            inst      = 32'hFFF00093;
            in_tag    = 8'd1;
            out_ready = 1'b0;
            for (int c = 0; c < 40 && delivered < 6; c++) begin
                @(negedge clk);
                if (in_valid && !in_ready32 && accepts_at_stall < 0)
                    accepts_at_stall = accepted;
                if (out_valid32 && out_ready) begin
                    check_value($sformatf("stream order %0d", delivered + 1),
                                64'(out_tag32), 64'(delivered + 1));
                    delivered++;
                    last_cycle = c;
                end
                if (in_valid && in_ready32) begin
                    accepted++;
                    next_in++;
                end
                @(posedge clk);
                #1;
                in_tag    = next_in;
                in_valid  = (accepted < 6);
                out_ready = (c + 1 >= 3);
            end
            in_valid = 1'b0;
            check_value("stream accepts before stall", 64'(accepts_at_stall), 64'd2);
            check_value("stream delivered count", 64'(delivered), 64'd6);
            check_value("stream last delivery cycle", 64'(last_cycle), 64'd8);
        end

        // Flush while FULL, with in_valid high in the flush cycle.
        out_ready = 1'b0;
        apply_stimulus(32'h00412083, 8'hA1);
        in_valid = 1'b1;
        in_tag   = 8'hA2;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_value("full before flush in_ready", 64'(in_ready32), 64'd0);
        #4;
        flush  = 1'b1;
        in_tag = 8'hA3;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_value("flush out_valid", 64'(out_valid32), 64'd0);
        check_value("flush in_ready",  64'(in_ready32),  64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_value($sformatf("post-flush quiet %0d", k), 64'(out_valid32), 64'd0);
        end

        // Flush in EMPTY while an input handshakes: the input is dropped.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_tag   = 8'hB1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check_value("flush drops handshaken input", 64'(out_valid32), 64'd0);

        // Asynchronous reset while one entry is held.
        out_ready = 1'b0;
        apply_stimulus(32'h0080006F, 8'hC1);
        @(negedge clk);
        check_value("one-state out_valid", 64'(out_valid32), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async reset out_valid", 64'(out_valid32), 64'd0);
        check_value("async reset in_ready",  64'(in_ready32),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_value("in_ready before first edge", 64'(in_ready32), 64'd0);
        @(posedge clk);
        #1;
        check_value("in_ready one edge after release", 64'(in_ready32), 64'd1);
        check_value("out_valid after reset release", 64'(out_valid32), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_imm_gen.md
RISCV_IMM_GEN -- requirements
Module: riscv_imm_gen

Interface
REQ-001 SHALL have parameter XLEN, 32, immediate/datapath width; legal values 32 and 64 only, anything else fails elaboration.
REQ-002 SHALL have parameter TAG_W, 8, width of sideband tag carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid  input  1  inst/in_tag valid.
REQ-007 SHALL have port in_ready  output  1  block can accept.
REQ-008 SHALL have port inst  input  32  raw RV32/RV64 instruction word.
REQ-009 SHALL have port in_tag  input  TAG_W  opaque sideband.
REQ-010 SHALL have port out_valid  output  1  out_* valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts.
REQ-012 SHALL have port out_imm  output  XLEN  sign-extended immediate.
REQ-013 SHALL have port out_fmt  output  3  immediate format code (imm_fmt_e).
REQ-014 SHALL have port out_tag  output  TAG_W  in_tag of the same instruction.

Function
REQ-015 SHALL decode format from inst[6:0]: LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> I; STORE 0100011 -> S; BRANCH 1100011 -> B; LUI 0110111, AUIPC 0010111 -> U; JAL 1101111 -> J; all else, including inst[1:0]!=2'b11 -> NONE.
REQ-016 SHALL build immediates: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}; NONE = 0.
REQ-017 SHALL sign-extend every immediate from its top bit (inst[31]) to XLEN, U included when XLEN=64.
REQ-018 SHALL transfer input when in_valid&&in_ready and output when out_valid&&out_ready.
REQ-019 SHALL present a result exactly 1 cycle after acceptance when not back-pressured (registered outputs, no combinational in->out path).
REQ-020 SHALL hold two entries (output register + skid register); states EMPTY, ONE, FULL.
REQ-021 SHALL drive in_ready = !(state==FULL), from a register, with no combinational dependence on out_ready.
REQ-022 Transitions: EMPTY+accept->ONE; ONE+accept without output transfer->FULL; ONE+output transfer without accept->EMPTY; ONE+both->ONE; FULL+output transfer->ONE (skid moves to output register); FULL never accepts.
REQ-023 SHALL preserve order and never drop or duplicate an entry; out_* stable while out_valid&&!out_ready.
REQ-024 flush SHALL force EMPTY next cycle, overriding any accept or output transfer in the same cycle; an input handshaken in the flush cycle is discarded.
REQ-025 out_imm/out_fmt/out_tag SHALL be don't-care while out_valid=0.

Reset
REQ-026 On rst_n low, asynchronously: state=EMPTY, out_valid=0, in_ready=0, out_imm=0, out_fmt=NONE, out_tag=0.
REQ-027 in_ready SHALL rise the first clk edge after rst_n deasserts; reset mid-stream loses all held entries without glitching out_valid high.

Structure
REQ-028 riscv_pkg SHALL hold imm_fmt_e (NONE=0,I,S,B,U,J) and the opcode localparams; riscv_imm_gen imports it.
REQ-029 The two-entry buffer SHALL be sub-module riscv_skid_buf (parametrised payload width); decode stays combinational inside riscv_imm_gen ahead of it.

Verification
REQ-030 XLEN=32, inst=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_fmt=I; 0xFE112E23 -> 0xFFFFFFFC, S.
REQ-031 inst=0xFE000EE3 -> 0xFFFFFFFC, B; 0x0080006F -> 0x00000008, J; 0x123450B7 -> 0x12345000, U; 0x00000033 -> 0, NONE.
REQ-032 XLEN=64: 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; 0x800000B7 (lui) -> 0xFFFFFFFF80000000.
REQ-033 Stream tags 1..6 back-to-back, out_ready low 3 cycles: in_ready drops after 2 accepts, outputs in order 1..6 with no loss, full throughput restored after release.
REQ-034 flush asserted in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, neither held entry nor flush-cycle input emerges.
REQ-035 rst_n pulsed low in ONE state -> out_valid=0 immediately (no clock edge), in_ready=1 one edge after release.
